button_event_decoder: RTL and testbench

Classifies the cleaned, debounced button level into discrete user events: short press, double press, long press, and auto-repeat while held. It sits directly downstream of the button debouncer and runs on the same slow clock. Each event is a single-cycle pulse for the control logic that follows. Durations are counted in slow-clock cycles, so all thresholds are parameters in ticks.

---
 rtl/button_event_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_button_event_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Turns a debounced button level into single-cycle user events: a short
// click, a double click, a long press and auto-repeat while a long press is
// held. Every duration is counted in ticks of the (slow) clock shared with
// the debouncer, so all thresholds are parameters expressed in ticks.
//
// Parameters
//   LONG_TICKS   : consecutive high samples that make a press "long" (>= 2)
//   GAP_TICKS    : consecutive low samples after a first release that close
//                  the click window (>= 1)
//   REPEAT_TICKS : high samples between auto-repeat pulses once long; 0 = off
//   CNT_W        : tick counter width, must hold the largest threshold
//
// Ports
//   clk          : slow system clock (single clock domain)
//   rst_n        : synchronous, active-low reset
//   button_level : debounced level, already synchronous to clk
//   short_press  : one-cycle pulse, single click
//   double_press : one-cycle pulse, second click inside the gap window
//   long_press   : one-cycle pulse when a press reaches LONG_TICKS
//   repeat_press : one-cycle pulse every REPEAT_TICKS while long press held
//   busy         : high whenever the FSM is not in IDLE
//
// All outputs are registered; each pulse appears in the cycle after the edge
// that sampled the qualifying button_level value.
// -----------------------------------------------------------------------------
module button_event_decoder #(
   parameter int unsigned LONG_TICKS   = 8,
   parameter int unsigned GAP_TICKS    = 4,
   parameter int unsigned REPEAT_TICKS = 3,
   parameter int unsigned CNT_W        = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_level,
   output logic short_press,
   output logic double_press,
   output logic long_press,
   output logic repeat_press,
   output logic busy
);

   // --------------------------------------------------------------------------
   // Elaboration-time parameter checks: a threshold the counter cannot hold
   // would silently never fire, so refuse to build instead.
   // --------------------------------------------------------------------------
   typedef longint unsigned u64_t;

   localparam u64_t CNT_LIMIT = (CNT_W >= 64) ? ~u64_t'(0)
                                              : ((u64_t'(1) << CNT_W) - u64_t'(1));

   if (LONG_TICKS < 2) begin : g_chk_long_min
      $error("button_event_decoder: LONG_TICKS must be at least 2");
   end
   if (GAP_TICKS < 1) begin : g_chk_gap_min
      $error("button_event_decoder: GAP_TICKS must be at least 1");
   end
   if (u64_t'(LONG_TICKS) > CNT_LIMIT) begin : g_chk_long_width
      $error("button_event_decoder: CNT_W too narrow for LONG_TICKS");
   end
   if (u64_t'(GAP_TICKS) > CNT_LIMIT) begin : g_chk_gap_width
      $error("button_event_decoder: CNT_W too narrow for GAP_TICKS");
   end
   if (u64_t'(REPEAT_TICKS) > CNT_LIMIT) begin : g_chk_rep_width
      $error("button_event_decoder: CNT_W too narrow for REPEAT_TICKS");
   end

   // Thresholds resized once to the counter width for clean comparisons.
   localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_TICKS);
   localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_TICKS);
   localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // --------------------------------------------------------------------------
   // State and counter
   // --------------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_RELEASE   = 3'd0,  // wait for the button to be seen low at least once
      ST_IDLE      = 3'd1,
      ST_PRESS1    = 3'd2,  // first press in progress, counting high samples
      ST_WAIT_GAP  = 3'd3,  // first press released, counting low samples
      ST_PRESS2    = 3'd4,  // second press of a double click
      ST_LONG_HELD = 3'd5   // long press reached, counting towards repeats
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_inc;

   logic short_reg;
   logic double_reg;
   logic long_reg;
   logic repeat_reg;
   logic busy_reg;

   // Saturating increment: one shared counter serves every state, and a
   // held button with repeat disabled must never wrap back to a threshold.
   assign cnt_inc = (cnt_reg == '1) ? cnt_reg : (cnt_reg + CNT_ONE);

   // --------------------------------------------------------------------------
   // FSM with registered outputs. busy_reg is written together with every
   // state change so it always reflects the state the FSM is about to hold.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= ST_RELEASE;
         cnt_reg    <= '0;
         short_reg  <= 1'b0;
         double_reg <= 1'b0;
         long_reg   <= 1'b0;
         repeat_reg <= 1'b0;
         busy_reg   <= 1'b1;
      end else begin
         // Event outputs are pulses: cleared unless set below this cycle.
         short_reg  <= 1'b0;
         double_reg <= 1'b0;
         long_reg   <= 1'b0;
         repeat_reg <= 1'b0;

         case (state_reg)
            ST_RELEASE: begin
               // A button held through reset must be released first so it
               // can never produce an event.
               cnt_reg <= '0;
               if (!button_level) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end

            ST_IDLE: begin
               if (button_level) begin
                  // The sample that leaves IDLE is the first high sample.
                  state_reg <= ST_PRESS1;
                  cnt_reg   <= CNT_ONE;
                  busy_reg  <= 1'b1;
               end else begin
                  cnt_reg   <= '0;
               end
            end

            ST_PRESS1: begin
               if (button_level) begin
                  if (cnt_inc == LONG_C) begin
                     long_reg  <= 1'b1;
                     state_reg <= ST_LONG_HELD;
                     cnt_reg   <= '0;
                  end else begin
                     cnt_reg   <= cnt_inc;
                  end
               end else if (GAP_TICKS == 1) begin
                  // The release sample itself is the last gap sample.
                  short_reg <= 1'b1;
                  state_reg <= ST_IDLE;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
               end else begin
                  // The release sample is the first low sample of the gap.
                  state_reg <= ST_WAIT_GAP;
                  cnt_reg   <= CNT_ONE;
               end
            end

            ST_WAIT_GAP: begin
               // A high sample wins even on the would-be final gap sample.
               if (button_level) begin
                  state_reg <= ST_PRESS2;
                  cnt_reg   <= '0;
               end else if (cnt_inc == GAP_C) begin
                  short_reg <= 1'b1;
                  state_reg <= ST_IDLE;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
               end else begin
                  cnt_reg   <= cnt_inc;
               end
            end

            ST_PRESS2: begin
               // Second press may last any time; no long/repeat detection.
               cnt_reg <= '0;
               if (!button_level) begin
                  double_reg <= 1'b1;
                  state_reg  <= ST_IDLE;
                  busy_reg   <= 1'b0;
               end
            end

            ST_LONG_HELD: begin
               if (button_level) begin
                  if ((REPEAT_TICKS != 0) && (cnt_inc == REPEAT_C)) begin
                     repeat_reg <= 1'b1;
                     cnt_reg    <= '0;
                  end else begin
                     cnt_reg    <= cnt_inc;
                  end
               end else begin
                  // Release after a long press is silent.
                  state_reg <= ST_IDLE;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
               end
            end

            default: begin
               state_reg <= ST_RELEASE;
               cnt_reg   <= '0;
               busy_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign short_press  = short_reg;
   assign double_press = double_reg;
   assign long_press   = long_reg;
   assign repeat_press = repeat_reg;
   assign busy         = busy_reg;

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//
// Scoreboard bench for button_event_decoder with default parameters
// (LONG_TICKS=8, GAP_TICKS=4, REPEAT_TICKS=3). Each stimulus step drives
// rst_n/button_level on the falling edge and pushes the outputs expected
// after the following rising edge; a monitor pops and compares them 1 ns
// after that rising edge. Expected values are written out per scenario from
// the tick counts of the behaviour being exercised.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

   localparam logic [3:0] EV_NONE = 4'b0000;
   localparam logic [3:0] EV_S    = 4'b1000;  // short
   localparam logic [3:0] EV_D    = 4'b0100;  // double
   localparam logic [3:0] EV_L    = 4'b0010;  // long
   localparam logic [3:0] EV_R    = 4'b0001;  // repeat

   typedef struct {
      string      tag;
      logic [4:0] exp;   // {busy, short, double, long, repeat}
   } exp_item_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic button_level = 1'b1;
   logic short_press;
   logic double_press;
   logic long_press;
   logic repeat_press;
   logic busy;

   int checks_cnt = 0;
   int errors_cnt = 0;

   exp_item_t exp_q[$];

   button_event_decoder #(
      .LONG_TICKS   (8),
      .GAP_TICKS    (4),
      .REPEAT_TICKS (3),
      .CNT_W        (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .button_level (button_level),
      .short_press  (short_press),
      .double_press (double_press),
      .long_press   (long_press),
      .repeat_press (repeat_press),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [4:0] got,
                              input logic [4:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got busy/s/d/l/r=%b exp=%b", tag, got, exp);
      end
   endtask

   // One sample: drive inputs, record what must appear after the next edge.
   task automatic step(input string tag, input logic rst, input logic lvl,
                       input logic exp_busy, input logic [3:0] exp_ev);
      exp_item_t item;
      @(negedge clk);
      rst_n        = rst;
      button_level = lvl;
      item.tag     = tag;
      item.exp     = {exp_busy, exp_ev};
      exp_q.push_back(item);
   endtask

   task automatic steps(input string tag, input logic rst, input logic lvl,
                        input int n, input logic exp_busy);
      for (int i = 0; i < n; i++) begin
         step($sformatf("%s%0d", tag, i + 1), rst, lvl, exp_busy, EV_NONE);
      end
   endtask

   // Monitor: one line per sampled transaction.
   initial begin
      exp_item_t item;
      logic [4:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            item = exp_q.pop_front();
            got  = {busy, short_press, double_press, long_press, repeat_press};
            $display("t=%0t %-10s rst_n=%0b lvl=%0b out=%b exp=%b",
                     $time, item.tag, rst_n, button_level, got, item.exp);
            check_value(item.tag, got, item.exp);
         end
      end
   end

   // Watchdog: the run must end on its own.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int waited;

      // Reset with the button held; stays in RELEASE while held.
      steps("rst", 1'b0, 1'b1, 2, 1'b1);
      steps("held", 1'b1, 1'b1, 20, 1'b1);
      step("rel_low", 1'b1, 1'b0, 1'b0, EV_NONE);
      steps("idle_a", 1'b1, 1'b0, 2, 1'b0);

      // Short click: 3 high, 4 low.
      steps("sh_hi", 1'b1, 1'b1, 3, 1'b1);
      steps("sh_lo", 1'b1, 1'b0, 3, 1'b1);
      step("sh_lo4", 1'b1, 1'b0, 1'b0, EV_S);
      steps("idle_b", 1'b1, 1'b0, 2, 1'b0);

      // Double click: 3 high, 2 low, 2 high, low.
      steps("db_hi", 1'b1, 1'b1, 3, 1'b1);
      steps("db_lo", 1'b1, 1'b0, 2, 1'b1);
      steps("db_hi2_", 1'b1, 1'b1, 2, 1'b1);
      step("db_rel", 1'b1, 1'b0, 1'b0, EV_D);
      steps("idle_c", 1'b1, 1'b0, 5, 1'b0);

      // Long press with repeats: 14 high then release.
      steps("lg_hi", 1'b1, 1'b1, 7, 1'b1);
      step("lg_hi8", 1'b1, 1'b1, 1'b1, EV_L);
      steps("lg_hi9_", 1'b1, 1'b1, 2, 1'b1);
      step("lg_hi11", 1'b1, 1'b1, 1'b1, EV_R);
      steps("lg_hi12_", 1'b1, 1'b1, 2, 1'b1);
      step("lg_hi14", 1'b1, 1'b1, 1'b1, EV_R);
      step("lg_rel", 1'b1, 1'b0, 1'b0, EV_NONE);
      steps("idle_d", 1'b1, 1'b0, 3, 1'b0);

      // One short of long: 7 high, 4 low -> short only.
      steps("p7_hi", 1'b1, 1'b1, 7, 1'b1);
      steps("p7_lo", 1'b1, 1'b0, 3, 1'b1);
      step("p7_lo4", 1'b1, 1'b0, 1'b0, EV_S);
      steps("idle_e", 1'b1, 1'b0, 1, 1'b0);

      // 7 high, 3 low, high -> PRESS2 (no short), release -> double.
      steps("g3_hi", 1'b1, 1'b1, 7, 1'b1);
      steps("g3_lo", 1'b1, 1'b0, 3, 1'b1);
      steps("g3_hi2_", 1'b1, 1'b1, 3, 1'b1);
      step("g3_rel", 1'b1, 1'b0, 1'b0, EV_D);
      steps("idle_f", 1'b1, 1'b0, 2, 1'b0);

      // Reset at the 5th high sample; held button must not create events.
      steps("rm_hi", 1'b1, 1'b1, 4, 1'b1);
      step("rm_rst", 1'b0, 1'b1, 1'b1, EV_NONE);
      steps("rm_held", 1'b1, 1'b1, 10, 1'b1);
      step("rm_low", 1'b1, 1'b0, 1'b0, EV_NONE);
      steps("idle_g", 1'b1, 1'b0, 2, 1'b0);

      // Reset while a short click is pending in the gap window.
      steps("rg_hi", 1'b1, 1'b1, 2, 1'b1);
      steps("rg_lo", 1'b1, 1'b0, 3, 1'b1);
      step("rg_rst", 1'b0, 1'b0, 1'b1, EV_NONE);
      step("rg_rel", 1'b1, 1'b0, 1'b0, EV_NONE);
      steps("idle_h", 1'b1, 1'b0, 4, 1'b0);

      // Drain the scoreboard with a bounded wait.
      waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      #2;
      check_value("drain", 5'(exp_q.size()), 5'd0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
